// File: rtl/sha2_pkg.sv
// Shared SHA-224/256 constants, state encoding and bitwise round helpers
// for the round engine and its single-round datapath.
package sha2_pkg;

   localparam int WORD_W = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ROUND = 2'd1,
      FINAL = 2'd2
   } sha2_state_e;

   // Field order matches digest packing: a (H0) in the top word, h (H7) at the bottom.
   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] c;
      logic [31:0] d;
      logic [31:0] e;
      logic [31:0] f;
      logic [31:0] g;
      logic [31:0] h;
   } sha2_vars_t;

   localparam logic [255:0] IV_256 = {
      32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
      32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

   localparam logic [255:0] IV_224 = {
      32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
      32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4};

   localparam logic [31:0] K [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

   function automatic logic [31:0] big_sigma0(input logic [31:0] x);
      return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
   endfunction

   function automatic logic [31:0] big_sigma1(input logic [31:0] x);
      return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
   endfunction

   function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y,
                                      input logic [31:0] z);
      return (x & y) ^ (~x & z);
   endfunction

   function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y,
                                       input logic [31:0] z);
      return (x & y) ^ (x & z) ^ (y & z);
   endfunction

   function automatic logic [255:0] iv_sel(input logic is_224);
      return is_224 ? IV_224 : IV_256;
   endfunction

   // SHA-224 publishes only H0..H6.
   function automatic logic [255:0] digest_mask(input logic [255:0] h, input logic is_224);
      return is_224 ? {h[255:32], 32'h0} : h;
   endfunction

endpackage

// File: rtl/sha2_round_fn.sv
// Combinational single SHA-256 compression round: (a..h, K, W) -> next a..h.
module sha2_round_fn
   import sha2_pkg::*;
(
   input  sha2_vars_t  vars_i,
   input  logic [31:0] k_i,
   input  logic [31:0] w_i,
   output sha2_vars_t  vars_o
);

   logic [31:0] t1;
   logic [31:0] t2;

   always_comb begin
      t1 = vars_i.h + big_sigma1(vars_i.e) + ch(vars_i.e, vars_i.f, vars_i.g) + k_i + w_i;
      t2 = big_sigma0(vars_i.a) + maj(vars_i.a, vars_i.b, vars_i.c);
      vars_o.a = t1 + t2;
      vars_o.b = vars_i.a;
      vars_o.c = vars_i.b;
      vars_o.d = vars_i.c;
      vars_o.e = vars_i.d + t1;
      vars_o.f = vars_i.e;
      vars_o.g = vars_i.f;
      vars_o.h = vars_i.g;
   end

endmodule

// File: rtl/sha2_round_engine.sv
// SHA-224/256 block compression engine: P_UNROLL rounds per accepted schedule
// beat, final chaining add, multi-block chaining and a held digest register.
//
// state | meaning
// IDLE  | waiting for start; digest holds last result
// ROUND | accepting W beats, P_UNROLL rounds per beat
// FINAL | H += a..h, digest captured, done next cycle
module sha2_round_engine
   import sha2_pkg::*;
#(
   parameter int P_UNROLL = 1,
   parameter int P_WIDTH  = 32
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic                         start,
   input  logic                         mode_224,
   input  logic                         first_blk,
   input  logic                         w_valid,
   output logic                         w_ready,
   input  logic [P_WIDTH*P_UNROLL-1:0]  w_data,
   output logic                         busy,
   output logic                         done,
   output logic [255:0]                 digest
);

   if (P_UNROLL != 1 && P_UNROLL != 2 && P_UNROLL != 4) begin : g_bad_unroll
      $error("sha2_round_engine: P_UNROLL must be 1, 2 or 4");
   end
   if (P_WIDTH != WORD_W) begin : g_bad_width
      $error("sha2_round_engine: P_WIDTH must be 32");
   end

   localparam logic [5:0] T_STEP = 6'(P_UNROLL);
   localparam logic [5:0] T_LAST = 6'(64 - P_UNROLL);

   sha2_state_e  state_q, state_d;
   logic [5:0]   t_q, t_d;
   logic         mode_q, mode_d;
   sha2_vars_t   vars_q, vars_d;
   logic [255:0] hash_q, hash_d;
   logic [255:0] digest_q, digest_d;
   logic         done_q, done_d;

   sha2_vars_t   chain [P_UNROLL+1];

   assign chain[0] = vars_q;

   for (genvar gi = 0; gi < P_UNROLL; gi++) begin : g_round
      logic [5:0] k_idx;
      assign k_idx = t_q + 6'(gi);
      sha2_round_fn u_round (
         .vars_i (chain[gi]),
         .k_i    (K[k_idx]),
         .w_i    (w_data[gi*32 +: 32]),
         .vars_o (chain[gi+1])
      );
   end

   always_comb begin
      state_d  = state_q;
      t_d      = t_q;
      mode_d   = mode_q;
      vars_d   = vars_q;
      hash_d   = hash_q;
      digest_d = digest_q;
      done_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               mode_d = mode_224;
               if (first_blk) begin
                  hash_d = iv_sel(mode_224);
                  vars_d = iv_sel(mode_224);
               end else begin
                  vars_d = hash_q;
               end
               t_d     = '0;
               state_d = ROUND;
            end
         end
         ROUND: begin
            if (w_valid) begin
               vars_d = chain[P_UNROLL];
               t_d    = t_q + T_STEP;
               if (t_q == T_LAST) begin
                  state_d = FINAL;
               end
            end
         end
         FINAL: begin
            for (int i = 0; i < 8; i++) begin
               hash_d[32*i +: 32] = hash_q[32*i +: 32] + vars_q[32*i +: 32];
            end
            // Digest only moves here so it never exposes a block in flight.
            digest_d = digest_mask(hash_d, mode_q);
            done_d   = 1'b1;
            state_d  = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         t_q      <= '0;
         mode_q   <= 1'b0;
         vars_q   <= IV_256;
         hash_q   <= IV_256;
         digest_q <= IV_256;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         t_q      <= t_d;
         mode_q   <= mode_d;
         vars_q   <= vars_d;
         hash_q   <= hash_d;
         digest_q <= digest_d;
         done_q   <= done_d;
      end
   end

   assign w_ready = (state_q == ROUND);
   assign busy    = (state_q != IDLE);
   assign done    = done_q;
   assign digest  = digest_q;

endmodule

// File: tb/tb_sha2_round_engine.sv
// Self-checking bench: three engines (P_UNROLL 1/2/4) against a message-level
// SHA-256 model, plus literal digests from the published test vectors.
module tb_sha2_round_engine;

   typedef logic [2047:0] wsched_t;

   localparam logic [31:0] KT [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

   localparam logic [255:0] T_IV256 = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
   localparam logic [255:0] T_IV224 = 256'hc1059ed8367cd5073070dd17f70e5939ffc00b316858151164f98fa7befa4fa4;
   localparam logic [255:0] D_ABC256 = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
   localparam logic [255:0] D_ABC224 = 256'h23097d223405d8228642a477bda255b32aadbce4bda0b3f7e36c9da700000000;
   localparam logic [255:0] D_TWO    = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

   localparam logic [511:0] BLK_ABC = {32'h61626380, 448'h0, 32'h00000018};
   localparam logic [511:0] BLK_TWO1 = {
      32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
      32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
      32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
      32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
   localparam logic [511:0] BLK_TWO2 = {480'h0, 32'h000001c0};

   logic         clk;
   logic         rst_n;
   logic [2:0]   start_s, mode_s, first_s, w_valid_s;
   logic [2:0]   w_ready_s, busy_s, done_s;
   logic [127:0] w_data_s [3];
   logic [255:0] dig_s [3];

   int errors = 0;
   int checks = 0;
   bit chk_en = 0;

   // Model state per engine
   bit           m_act  [3];
   bit           m_fin  [3];
   bit           m_done [3];
   bit           m_mode [3];
   int           m_cnt  [3];
   wsched_t      m_w    [3];
   logic [255:0] m_hash [3];
   logic [255:0] m_dig  [3];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   sha2_round_engine #(.P_UNROLL(1)) u_dut0 (
      .clk(clk), .reset_n(rst_n), .start(start_s[0]), .mode_224(mode_s[0]),
      .first_blk(first_s[0]), .w_valid(w_valid_s[0]), .w_ready(w_ready_s[0]),
      .w_data(w_data_s[0][31:0]), .busy(busy_s[0]), .done(done_s[0]), .digest(dig_s[0]));

   sha2_round_engine #(.P_UNROLL(2)) u_dut1 (
      .clk(clk), .reset_n(rst_n), .start(start_s[1]), .mode_224(mode_s[1]),
      .first_blk(first_s[1]), .w_valid(w_valid_s[1]), .w_ready(w_ready_s[1]),
      .w_data(w_data_s[1][63:0]), .busy(busy_s[1]), .done(done_s[1]), .digest(dig_s[1]));

   sha2_round_engine #(.P_UNROLL(4)) u_dut2 (
      .clk(clk), .reset_n(rst_n), .start(start_s[2]), .mode_224(mode_s[2]),
      .first_blk(first_s[2]), .w_valid(w_valid_s[2]), .w_ready(w_ready_s[2]),
      .w_data(w_data_s[2]), .busy(busy_s[2]), .done(done_s[2]), .digest(dig_s[2]));

   function automatic logic [31:0] ror(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic wsched_t expand(input logic [511:0] blk);
      wsched_t w;
      logic [31:0] s0, s1, wm2, wm15;
      w = '0;
      for (int t = 0; t < 64; t++) begin
         if (t < 16) begin
            w[32*t +: 32] = blk[511-32*t -: 32];
         end else begin
            wm2  = w[32*(t-2) +: 32];
            wm15 = w[32*(t-15) +: 32];
            s0 = ror(wm15, 7) ^ ror(wm15, 18) ^ (wm15 >> 3);
            s1 = ror(wm2, 17) ^ ror(wm2, 19) ^ (wm2 >> 10);
            w[32*t +: 32] = s1 + w[32*(t-7) +: 32] + s0 + w[32*(t-16) +: 32];
         end
      end
      return w;
   endfunction

   function automatic logic [255:0] compress(input logic [255:0] hin, input wsched_t w);
      logic [31:0] v [8];
      logic [31:0] t1, t2;
      logic [255:0] hout;
      for (int i = 0; i < 8; i++) v[i] = hin[255-32*i -: 32];
      for (int t = 0; t < 64; t++) begin
         t1 = v[7] + (ror(v[4], 6) ^ ror(v[4], 11) ^ ror(v[4], 25))
                   + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[t] + w[32*t +: 32];
         t2 = (ror(v[0], 2) ^ ror(v[0], 13) ^ ror(v[0], 22))
            + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
         for (int j = 7; j > 0; j--) v[j] = v[j-1];
         v[4] = v[4] + t1;
         v[0] = t1 + t2;
      end
      for (int i = 0; i < 8; i++) hout[255-32*i -: 32] = hin[255-32*i -: 32] + v[i];
      return hout;
   endfunction

   task automatic check(input string nm, input int idx, input logic [255:0] act,
                        input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s[%0d] actual=%h required=%h", nm, idx, act, exp);
      end
   endtask

   // Block-level model: collects accepted W words, compresses once all 64 are in.
   always @(posedge clk or negedge rst_n) begin : p_model
      wsched_t      tmp;
      logic [255:0] nh;
      int           p;
      for (int i = 0; i < 3; i++) begin
         p = 1 << i;
         if (!rst_n) begin
            m_act[i]  <= 1'b0;
            m_fin[i]  <= 1'b0;
            m_done[i] <= 1'b0;
            m_mode[i] <= 1'b0;
            m_cnt[i]  <= 0;
            m_w[i]    <= '0;
            m_hash[i] <= T_IV256;
            m_dig[i]  <= T_IV256;
         end else begin
            m_done[i] <= 1'b0;
            if (m_fin[i]) begin
               nh = compress(m_hash[i], m_w[i]);
               m_hash[i] <= nh;
               m_dig[i]  <= m_mode[i] ? {nh[255:32], 32'h0} : nh;
               m_done[i] <= 1'b1;
               m_fin[i]  <= 1'b0;
            end else if (m_act[i]) begin
               if (w_valid_s[i]) begin
                  tmp = m_w[i];
                  for (int l = 0; l < p; l++) tmp[32*(m_cnt[i]+l) +: 32] = w_data_s[i][32*l +: 32];
                  m_w[i]   <= tmp;
                  m_cnt[i] <= m_cnt[i] + p;
                  if (m_cnt[i] + p == 64) begin
                     m_act[i] <= 1'b0;
                     m_fin[i] <= 1'b1;
                  end
               end
            end else if (start_s[i]) begin
               m_mode[i] <= mode_s[i];
               if (first_s[i]) m_hash[i] <= mode_s[i] ? T_IV224 : T_IV256;
               m_cnt[i] <= 0;
               m_act[i] <= 1'b1;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         for (int i = 0; i < 3; i++) begin
            check("busy", i, 256'(busy_s[i]), 256'(m_act[i] | m_fin[i]));
            check("w_ready", i, 256'(w_ready_s[i]), 256'(m_act[i]));
            check("done", i, 256'(done_s[i]), 256'(m_done[i]));
            check("digest", i, dig_s[i], m_dig[i]);
         end
      end
   end

   // Starts at a negedge with the engine idle (or in its done cycle) and returns
   // at the negedge where done is seen. lat counts negedges from the start cycle.
   task automatic send_block(input int idx, input logic [511:0] blk, input bit mode,
                             input bit first, input bit gaps, input bit poke,
                             input int abort_beats, output int lat, output int last_gap);
      wsched_t w;
      int p, ptr, cyc, last;
      w = expand(blk);
      p = 1 << idx;
      ptr = 0;
      cyc = 0;
      last = 0;
      lat = -1;
      last_gap = -1;
      start_s[idx] = 1'b1;
      mode_s[idx] = mode;
      first_s[idx] = first;
      w_valid_s[idx] = 1'b0;
      while (ptr < 64 && cyc < 300) begin
         @(negedge clk);
         cyc++;
         start_s[idx] = 1'b0;
         w_valid_s[idx] = 1'b1;
         w_data_s[idx] = {$urandom, $urandom, $urandom, $urandom};
         if (w_ready_s[idx]) begin
            if (gaps && $urandom_range(2) == 0) begin
               w_valid_s[idx] = 1'b0;
            end else begin
               for (int l = 0; l < p; l++) w_data_s[idx][32*l +: 32] = w[32*(ptr+l) +: 32];
               ptr += p;
               last = cyc;
            end
         end
         if (poke && ptr >= 24 && ptr < 32) begin
            start_s[idx] = 1'b1;
            first_s[idx] = 1'b1;
            mode_s[idx] = ~mode;
         end
         if (abort_beats > 0 && ptr >= abort_beats) begin
            @(posedge clk);
            #1;
            rst_n = 1'b0;
            w_valid_s[idx] = 1'b0;
            start_s[idx] = 1'b0;
            return;
         end
      end
      while (!done_s[idx] && cyc < 300) begin
         @(negedge clk);
         cyc++;
         start_s[idx] = 1'b0;
         w_valid_s[idx] = 1'b1;
         w_data_s[idx] = {$urandom, $urandom, $urandom, $urandom};
      end
      w_valid_s[idx] = 1'b0;
      start_s[idx] = 1'b0;
      if (!done_s[idx]) begin
         errors++;
         $display("FAIL timeout[%0d] no done after %0d cycles, required done", idx, cyc);
      end else begin
         lat = cyc;
         last_gap = cyc - last;
      end
   endtask

   task automatic idle_junk(input int idx, input int n);
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         w_valid_s[idx] = 1'b1;
         w_data_s[idx] = {$urandom, $urandom, $urandom, $urandom};
      end
      @(negedge clk);
      w_valid_s[idx] = 1'b0;
   endtask

   initial begin
      int lat, gap;
      rst_n = 1'b0;
      start_s = '0;
      mode_s = '0;
      first_s = '0;
      w_valid_s = '0;
      for (int i = 0; i < 3; i++) w_data_s[i] = '0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      chk_en = 1'b1;
      @(negedge clk);

      check("rst_digest", 0, dig_s[0], T_IV256);
      check("rst_busy", 0, 256'(busy_s[0]), 256'(0));
      check("rst_ready", 0, 256'(w_ready_s[0]), 256'(0));
      check("rst_done", 0, 256'(done_s[0]), 256'(0));

      send_block(0, BLK_ABC, 1'b0, 1'b1, 1'b0, 1'b0, 0, lat, gap);
      check("lat_p1", 0, 256'(lat), 256'(66));
      check("abc256", 0, dig_s[0], D_ABC256);
      check("model_abc256", 0, m_dig[0], D_ABC256);

      send_block(0, BLK_ABC, 1'b1, 1'b1, 1'b0, 1'b0, 0, lat, gap);
      check("abc224", 0, dig_s[0], D_ABC224);
      check("model_abc224", 0, m_dig[0], D_ABC224);

      // Chain from the SHA-224 H with the mode switched back to SHA-256.
      send_block(0, BLK_ABC, 1'b0, 1'b0, 1'b0, 1'b0, 0, lat, gap);
      idle_junk(0, 4);

      send_block(0, BLK_TWO1, 1'b0, 1'b1, 1'b0, 1'b0, 0, lat, gap);
      send_block(0, BLK_TWO2, 1'b0, 1'b0, 1'b0, 1'b0, 0, lat, gap);
      check("lat_chain", 0, 256'(lat), 256'(66));
      check("two_block", 0, dig_s[0], D_TWO);
      check("model_two_block", 0, m_dig[0], D_TWO);

      idle_junk(0, 2);
      send_block(0, BLK_ABC, 1'b0, 1'b1, 1'b0, 1'b1, 0, lat, gap);
      check("abc_poke", 0, dig_s[0], D_ABC256);

      send_block(1, BLK_ABC, 1'b0, 1'b1, 1'b0, 1'b0, 0, lat, gap);
      check("lat_p2", 1, 256'(lat), 256'(34));
      check("abc_p2", 1, dig_s[1], D_ABC256);
      send_block(1, BLK_ABC, 1'b0, 1'b1, 1'b1, 1'b0, 0, lat, gap);
      check("gap_done_p2", 1, 256'(gap), 256'(2));
      check("abc_p2_gaps", 1, dig_s[1], D_ABC256);

      send_block(2, BLK_ABC, 1'b0, 1'b1, 1'b0, 1'b0, 0, lat, gap);
      check("lat_p4", 2, 256'(lat), 256'(18));
      check("abc_p4", 2, dig_s[2], D_ABC256);
      send_block(2, BLK_ABC, 1'b1, 1'b1, 1'b1, 1'b0, 0, lat, gap);
      check("gap_done_p4", 2, 256'(gap), 256'(2));
      check("abc224_p4_gaps", 2, dig_s[2], D_ABC224);

      send_block(0, BLK_ABC, 1'b0, 1'b1, 1'b1, 1'b0, 0, lat, gap);
      check("gap_done_p1", 0, 256'(gap), 256'(2));
      check("abc_p1_gaps", 0, dig_s[0], D_ABC256);

      @(negedge clk);
      send_block(0, BLK_ABC, 1'b1, 1'b1, 1'b0, 1'b0, 20, lat, gap);
      @(negedge clk);
      check("abort_busy", 0, 256'(busy_s[0]), 256'(0));
      check("abort_ready", 0, 256'(w_ready_s[0]), 256'(0));
      check("abort_done", 0, 256'(done_s[0]), 256'(0));
      check("abort_digest", 0, dig_s[0], T_IV256);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      send_block(0, BLK_ABC, 1'b0, 1'b1, 1'b0, 1'b0, 0, lat, gap);
      check("abc_after_reset", 0, dig_s[0], D_ABC256);

      repeat (3) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
